gate_vector_checker: RTL and testbench



---
 rtl/gate_vector_checker.sv | 247 ++++++++++++++++++++++++
 tb/tb_gate_vector_checker.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_vector_checker.sv
// -----------------------------------------------------------------------------
// gate_vector_checker
//
// Purpose:
//   Self-checking stage placed behind the 2-input logic-gate bank. Each
//   accepted vector (a, b, gate_out) is registered in a single pipeline stage
//   and compared one clock later against the golden truth table. Over one run
//   of NUM_VEC vectors the block accumulates:
//     - a vector count
//     - a saturating error count
//     - input-combination coverage
//   It then raises done together with a pass verdict.
//
// Parameters:
//   NUM_VEC : vectors accepted per run (>= 1, must be < 2**CNT_W)
//   CNT_W   : width of vec_cnt / err_cnt / first_fail_idx (>= 2)
//
// Optional feature (compile-time macro GVC_FIRST_FAIL_EN):
//   When defined, the index and mismatch mask of the first failing vector of
//   a run are captured in first_fail_idx / first_fail_mask. When undefined,
//   both outputs are tied to 0 and no capture registers exist.
//
// Ports:
//   clk             in   rising-edge clock
//   rst             in   synchronous active-high reset
//   start           in   begin a run (honoured in IDLE and DONE only)
//   in_valid        in   a, b, gate_out valid this cycle
//   a, b            in   gate inputs as applied
//   gate_out[6:0]   in   [0]and [1]or [2]not-a [3]nand [4]nor [5]xor [6]xnor
//   in_ready        out  high while vectors are being accepted
//   busy            out  run in progress
//   done            out  run complete, results stable
//   pass            out  done && err_cnt==0 && cov==4'b1111
//   vec_cnt         out  vectors accepted this run
//   err_cnt         out  mismatching vectors (saturating)
//   cov[3:0]        out  bit {a,b} set once that combination was seen
//   first_fail_idx  out  0-based index of the first mismatching vector
//   first_fail_mask out  mismatch bits of the first failing vector
// -----------------------------------------------------------------------------
module gate_vector_checker #(
  parameter int NUM_VEC = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic             a,
  input  logic             b,
  input  logic [6:0]       gate_out,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [3:0]       cov,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [6:0]       first_fail_mask
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_VEC);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [3:0]       cov_q, cov_d;
  logic             s1_valid_q, s1_valid_d;
  logic             s1_a_q, s1_a_d;
  logic             s1_b_q, s1_b_d;
  logic [6:0]       s1_gate_q, s1_gate_d;

  logic             run_full;
  logic             accept;
  logic             clear;
  logic [6:0]       exp_vec;
  logic [6:0]       mask;
  logic             mismatch;

  // All NUM_VEC vectors have been taken; only the S1 drain remains.
  assign run_full = (vec_cnt_q == LAST_CNT);
  assign accept   = in_valid && in_ready;
  assign clear    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        // Leave RUN on the edge that commits the last compare.
        if (run_full && s1_valid_q) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready = (state_q == ST_RUN) && !run_full;
    busy     = (state_q == ST_RUN);
    done     = (state_q == ST_DONE);
    pass     = (state_q == ST_DONE) && (err_cnt_q == '0) && (cov_q == 4'b1111);
  end

  // ---------------------------------------------------------------------------
  // Compare stage: golden vector from the registered inputs
  // ---------------------------------------------------------------------------
  assign exp_vec = {~(s1_a_q ^ s1_b_q), s1_a_q ^ s1_b_q, ~(s1_a_q | s1_b_q),
                    ~(s1_a_q & s1_b_q), ~s1_a_q, s1_a_q | s1_b_q, s1_a_q & s1_b_q};

  // A bit is only cleared when it is known to match. An X/Z on gate_out makes
  // the equality unknown, the if is not taken and the bit stays flagged.
  always_comb begin
    for (int i = 0; i < 7; i++) begin
      mask[i] = 1'b1;
      if (s1_gate_q[i] == exp_vec[i]) mask[i] = 1'b0;
    end
  end

  assign mismatch = s1_valid_q && (mask != 7'd0);

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    vec_cnt_d  = vec_cnt_q;
    err_cnt_d  = err_cnt_q;
    cov_d      = cov_q;
    s1_valid_d = accept;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_gate_d  = s1_gate_q;

    if (clear) begin
      // S1 is always empty in IDLE/DONE, so nothing is lost here.
      vec_cnt_d = '0;
      err_cnt_d = '0;
      cov_d     = 4'b0000;
    end else begin
      if (mismatch && (err_cnt_q != CNT_MAX)) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
      if (accept) begin
        vec_cnt_d          = vec_cnt_q + CNT_W'(1);
        cov_d[{a, b}]      = 1'b1;
        s1_a_d             = a;
        s1_b_d             = b;
        s1_gate_d          = gate_out;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec_cnt_q  <= '0;
      err_cnt_q  <= '0;
      cov_q      <= 4'b0000;
      s1_valid_q <= 1'b0;
      s1_a_q     <= 1'b0;
      s1_b_q     <= 1'b0;
      s1_gate_q  <= 7'd0;
    end else begin
      vec_cnt_q  <= vec_cnt_d;
      err_cnt_q  <= err_cnt_d;
      cov_q      <= cov_d;
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_gate_q  <= s1_gate_d;
    end
  end

  assign vec_cnt = vec_cnt_q;
  assign err_cnt = err_cnt_q;
  assign cov     = cov_q;

  // ---------------------------------------------------------------------------
  // First-failure capture
  // ---------------------------------------------------------------------------
`ifdef GVC_FIRST_FAIL_EN
  logic [CNT_W-1:0] s1_idx_q, s1_idx_d;
  logic [CNT_W-1:0] ff_idx_q, ff_idx_d;
  logic [6:0]       ff_mask_q, ff_mask_d;

  always_comb begin
    s1_idx_d  = s1_idx_q;
    ff_idx_d  = ff_idx_q;
    ff_mask_d = ff_mask_q;
    if (clear) begin
      ff_idx_d  = '0;
      ff_mask_d = 7'd0;
    end else begin
      // err_cnt only returns to zero on clear/reset, so zero here means
      // "no mismatch yet in this run".
      if (mismatch && (err_cnt_q == '0)) begin
        ff_idx_d  = s1_idx_q;
        ff_mask_d = mask;
      end
      if (accept) s1_idx_d = vec_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_idx_q  <= '0;
      ff_idx_q  <= '0;
      ff_mask_q <= 7'd0;
    end else begin
      s1_idx_q  <= s1_idx_d;
      ff_idx_q  <= ff_idx_d;
      ff_mask_q <= ff_mask_d;
    end
  end

  assign first_fail_idx  = ff_idx_q;
  assign first_fail_mask = ff_mask_q;
`else
  assign first_fail_idx  = '0;
  assign first_fail_mask = 7'd0;
`endif

endmodule

// File: tb/tb_gate_vector_checker.sv
// -----------------------------------------------------------------------------
// tb_gate_vector_checker
//
// Two checker instances share all stimulus except start:
//   dut1: NUM_VEC=4, CNT_W=8 (default build)
//   dut2: NUM_VEC=3, CNT_W=2 (narrow counters)
// Each run pushes its expected result into a scoreboard queue when the
// vectors are generated. The entry is popped and compared once done rises.
// -----------------------------------------------------------------------------
module tb_gate_vector_checker;

  typedef struct {
    logic [7:0] vec_cnt;
    logic [7:0] err_cnt;
    logic [3:0] cov;
    logic       pass;
    logic [7:0] ff_idx;
    logic [6:0] ff_mask;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start1;
  logic       start2;
  logic       in_valid;
  logic       a;
  logic       b;
  logic [6:0] gate_out;

  logic       in_ready1, busy1, done1, pass1;
  logic [7:0] vec_cnt1, err_cnt1, ff_idx1;
  logic [3:0] cov1;
  logic [6:0] ff_mask1;

  logic       in_ready2, busy2, done2, pass2;
  logic [1:0] vec_cnt2, err_cnt2, ff_idx2;
  logic [3:0] cov2;
  logic [6:0] ff_mask2;

  gate_vector_checker #(.NUM_VEC(4), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .in_valid(in_valid),
    .a(a), .b(b), .gate_out(gate_out),
    .in_ready(in_ready1), .busy(busy1), .done(done1), .pass(pass1),
    .vec_cnt(vec_cnt1), .err_cnt(err_cnt1), .cov(cov1),
    .first_fail_idx(ff_idx1), .first_fail_mask(ff_mask1)
  );

  gate_vector_checker #(.NUM_VEC(3), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .in_valid(in_valid),
    .a(a), .b(b), .gate_out(gate_out),
    .in_ready(in_ready2), .busy(busy2), .done(done2), .pass(pass2),
    .vec_cnt(vec_cnt2), .err_cnt(err_cnt2), .cov(cov2),
    .first_fail_idx(ff_idx2), .first_fail_mask(ff_mask2)
  );

  // Observation mux: the task under way selects which instance it watches.
  logic       sel_dut;
  logic       o_in_ready, o_busy, o_done, o_pass;
  logic [7:0] o_vec_cnt, o_err_cnt, o_ff_idx;
  logic [3:0] o_cov;
  logic [6:0] o_ff_mask;

  assign o_in_ready = sel_dut ? in_ready2 : in_ready1;
  assign o_busy     = sel_dut ? busy2 : busy1;
  assign o_done     = sel_dut ? done2 : done1;
  assign o_pass     = sel_dut ? pass2 : pass1;
  assign o_vec_cnt  = sel_dut ? {6'd0, vec_cnt2} : vec_cnt1;
  assign o_err_cnt  = sel_dut ? {6'd0, err_cnt2} : err_cnt1;
  assign o_ff_idx   = sel_dut ? {6'd0, ff_idx2} : ff_idx1;
  assign o_cov      = sel_dut ? cov2 : cov1;
  assign o_ff_mask  = sel_dut ? ff_mask2 : ff_mask1;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  logic [1:0] stim_ab   [8];
  logic [6:0] stim_flip [8];
  bit         stim_x    [8];

  // Hand-derived truth table, bit6..bit0 = xnor xor nor nand not-a or and.
  function automatic logic [6:0] golden(input logic [1:0] ab);
    case (ab)
      2'b00:   return 7'b1011100;
      2'b01:   return 7'b0101110;
      2'b10:   return 7'b0101010;
      default: return 7'b1000011;
    endcase
  endfunction

  task automatic set_stim(input int i, input logic [1:0] ab, input logic [6:0] flip, input bit xb);
    stim_ab[i]   = ab;
    stim_flip[i] = flip;
    stim_x[i]    = xb;
  endtask

  task automatic load_good4();
    for (int i = 0; i < 4; i++) set_stim(i, 2'(i), 7'd0, 1'b0);
  endtask

  // Start a run on the selected instance, feed n vectors, wait for done and
  // compare against the scoreboard entry.
  task automatic run_vectors(input string name, input int n, input bit sel,
                             input bit gaps, input bit start_mid);
    exp_t       e;
    exp_t       g;
    logic [6:0] drv [8];
    logic [6:0] gold;
    logic [6:0] m;
    int         maxc;
    int         cyc;
    bit         seen;

    maxc = sel ? 3 : 255;
    e    = '{default: '0};
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      gold   = golden(stim_ab[i]);
      drv[i] = gold ^ stim_flip[i];
      if (stim_x[i]) drv[i][5] = 1'bx;
      for (int j = 0; j < 7; j++) m[j] = (drv[i][j] !== gold[j]);
      e.cov[stim_ab[i]] = 1'b1;
      if (m != 7'd0) begin
        if (!seen) begin
          e.ff_idx  = 8'(i);
          e.ff_mask = m;
          seen      = 1'b1;
        end
        if (int'(e.err_cnt) < maxc) e.err_cnt = e.err_cnt + 8'd1;
      end
    end
    e.vec_cnt = 8'(n);
    e.pass    = (e.err_cnt == 8'd0) && (e.cov == 4'b1111);
`ifndef GVC_FIRST_FAIL_EN
    e.ff_idx  = 8'd0;
    e.ff_mask = 7'd0;
`endif
    sb.push_back(e);

    sel_dut = sel;
    @(posedge clk); #1;
    if (sel) start2 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    start2 = 1'b0;
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_after_start: got %b expected 1", name, o_busy);
    end

    for (int i = 0; i < n; i++) begin
      checks++;
      if (o_in_ready !== 1'b1) begin
        errors++;
        $display("FAIL %s in_ready[%0d]: got %b expected 1", name, i, o_in_ready);
      end
      a        = stim_ab[i][1];
      b        = stim_ab[i][0];
      gate_out = drv[i];
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (gaps && i < n - 1) begin
        if (start_mid && i == 0) begin
          if (sel) start2 = 1'b1; else start1 = 1'b1;
        end
        @(posedge clk); #1;
        start1 = 1'b0;
        start2 = 1'b0;
        @(posedge clk); #1;
      end
    end

    checks++;
    if (o_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s in_ready_after_last: got %b expected 0", name, o_in_ready);
    end
    checks++;
    if (o_done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_early: got %b expected 0", name, o_done);
    end

    cyc = 0;
    while (o_done !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc != 1) begin
      errors++;
      $display("FAIL %s done_latency: got %0d cycles expected 1", name, cyc);
    end

    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard_empty: got 0 entries expected 1", name);
    end else begin
      g = sb.pop_front();
      checks++;
      if (o_vec_cnt !== g.vec_cnt) begin
        errors++;
        $display("FAIL %s vec_cnt: got %0d expected %0d", name, o_vec_cnt, g.vec_cnt);
      end
      checks++;
      if (o_err_cnt !== g.err_cnt) begin
        errors++;
        $display("FAIL %s err_cnt: got %0d expected %0d", name, o_err_cnt, g.err_cnt);
      end
      checks++;
      if (o_cov !== g.cov) begin
        errors++;
        $display("FAIL %s cov: got %b expected %b", name, o_cov, g.cov);
      end
      checks++;
      if (o_pass !== g.pass) begin
        errors++;
        $display("FAIL %s pass: got %b expected %b", name, o_pass, g.pass);
      end
      checks++;
      if (o_ff_idx !== g.ff_idx) begin
        errors++;
        $display("FAIL %s first_fail_idx: got %0d expected %0d", name, o_ff_idx, g.ff_idx);
      end
      checks++;
      if (o_ff_mask !== g.ff_mask) begin
        errors++;
        $display("FAIL %s first_fail_mask: got %b expected %b", name, o_ff_mask, g.ff_mask);
      end
      checks++;
      if (o_busy !== 1'b0) begin
        errors++;
        $display("FAIL %s busy_in_done: got %b expected 0", name, o_busy);
      end
      $display("run %s: vec_cnt=%0d err_cnt=%0d cov=%b pass=%b ff_idx=%0d ff_mask=%b",
               name, o_vec_cnt, o_err_cnt, o_cov, o_pass, o_ff_idx, o_ff_mask);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({in_ready1, busy1, done1, pass1} !== 4'b0000) begin
      errors++;
      $display("FAIL %s flags: got %b expected 0000", name, {in_ready1, busy1, done1, pass1});
    end
    checks++;
    if (vec_cnt1 !== 8'd0 || err_cnt1 !== 8'd0) begin
      errors++;
      $display("FAIL %s counts: got vec=%0d err=%0d expected 0 0", name, vec_cnt1, err_cnt1);
    end
    checks++;
    if (cov1 !== 4'd0) begin
      errors++;
      $display("FAIL %s cov: got %b expected 0000", name, cov1);
    end
    checks++;
    if (ff_idx1 !== 8'd0 || ff_mask1 !== 7'd0) begin
      errors++;
      $display("FAIL %s first_fail: got idx=%0d mask=%b expected 0", name, ff_idx1, ff_mask1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_all_zero("reset");
    checks++;
    if ({busy2, done2, in_ready2} !== 3'b000) begin
      errors++;
      $display("FAIL reset dut2_flags: got %b expected 000", {busy2, done2, in_ready2});
    end
    $display("reset: dut1 and dut2 idle");
  endtask

  task automatic test_all_pass();
    load_good4();
    run_vectors("all_pass", 4, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_single_error();
    load_good4();
    set_stim(3, 2'b11, 7'b0001000, 1'b0);
    run_vectors("single_error", 4, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_partial_cov();
    set_stim(0, 2'b00, 7'd0, 1'b0);
    set_stim(1, 2'b00, 7'd0, 1'b0);
    set_stim(2, 2'b01, 7'd0, 1'b0);
    set_stim(3, 2'b10, 7'd0, 1'b0);
    run_vectors("partial_cov", 4, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_x_bit();
    load_good4();
    set_stim(1, 2'b01, 7'd0, 1'b1);
    run_vectors("x_bit", 4, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    sel_dut = 1'b0;
    @(posedge clk); #1;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1   = 1'b0;
    a        = 1'b0;
    b        = 1'b0;
    gate_out = golden(2'b00) ^ 7'b0000001;
    in_valid = 1'b1;
    @(posedge clk); #1;
    a        = 1'b0;
    b        = 1'b1;
    gate_out = golden(2'b01);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (vec_cnt1 !== 8'd2 || err_cnt1 !== 8'd1) begin
      errors++;
      $display("FAIL mid_run pre_reset: got vec=%0d err=%0d expected 2 1", vec_cnt1, err_cnt1);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_all_zero("mid_reset");
    for (int i = 0; i < 3; i++) begin
      a        = i[0];
      b        = ~i[0];
      gate_out = 7'h55;
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_all_zero("idle_valid");
    $display("mid_run: reset cleared run, idle in_valid ignored");
    load_good4();
    run_vectors("after_reset", 4, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_gaps_and_start();
    load_good4();
    set_stim(2, 2'b10, 7'b1000001, 1'b0);
    run_vectors("gaps_start", 4, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 3; i++) set_stim(i, 2'(i + 1), 7'h7F, 1'b0);
    run_vectors("saturate_narrow", 3, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) set_stim(i, 2'(i), 7'd0, 1'b0);
    run_vectors("narrow_good", 3, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    load_good4();
    run_vectors("b2b_first", 4, 1'b0, 1'b0, 1'b0);
    a        = 1'b1;
    b        = 1'b1;
    gate_out = 7'd0;
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (vec_cnt1 !== 8'd4 || done1 !== 1'b1 || pass1 !== 1'b1) begin
      errors++;
      $display("FAIL done_hold: got vec=%0d done=%b pass=%b expected 4 1 1", vec_cnt1, done1, pass1);
    end
    set_stim(0, 2'b00, 7'b0000010, 1'b0);
    set_stim(1, 2'b01, 7'b0010000, 1'b0);
    run_vectors("b2b_second", 4, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst      = 1'b1;
    start1   = 1'b0;
    start2   = 1'b0;
    in_valid = 1'b0;
    a        = 1'b0;
    b        = 1'b0;
    gate_out = 7'd0;
    sel_dut  = 1'b0;
    for (int i = 0; i < 8; i++) set_stim(i, 2'b00, 7'd0, 1'b0);

    test_reset();
    test_all_pass();
    test_single_error();
    test_partial_cov();
    test_x_bit();
    test_reset_mid_run();
    test_gaps_and_start();
    test_saturation();
    test_back_to_back();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
